mano_io_channel: RTL and testbench

//  Parametrised, synthesizable character I/O peripheral for the Mano machine. Replaces

---
 rtl/mano_io_channel.sv | 124 ++++++++++++
 tb/tb_mano_io_channel.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mano_io_channel.sv
// mano_io_channel: character I/O front end for the Mano machine (input FIFO -> INPR/FGI, OUTR/FGO -> capture)
// Ports:
//   io_clock, io_reset        rising-edge clock, synchronous active-high reset
//   io_tx_valid/data/ready    host push interface into the input FIFO
//   io_fgi, io_fgiset         machine FGI flag in, one-cycle FGI set pulse out
//   io_inpr                   character offered to INPR, held until the next pop
//   io_fgo, io_outr           machine FGO flag and OUTR in
//   io_fgoset                 one-cycle FGO set pulse (after reset and after device latency)
//   io_rx_valid/data/count    capture pulse, last captured OUTR, wrapping capture count
module mano_io_channel #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int IN_GAP     = 4,
    parameter int OUT_LAT    = 8,
    parameter int CNT_W      = 16
) (
    input  logic              io_clock,
    input  logic              io_reset,
    input  logic              io_tx_valid,
    input  logic [DATA_W-1:0] io_tx_data,
    output logic              io_tx_ready,
    input  logic              io_fgi,
    output logic              io_fgiset,
    output logic [DATA_W-1:0] io_inpr,
    input  logic              io_fgo,
    input  logic [DATA_W-1:0] io_outr,
    output logic              io_fgoset,
    output logic              io_rx_valid,
    output logic [DATA_W-1:0] io_rx_data,
    output logic [CNT_W-1:0]  io_rx_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (IN_GAP > 0) ? $clog2(IN_GAP + 1) : 1;
    localparam int LW = $clog2(OUT_LAT + 1);
    localparam logic [1:0] IN_IDLE  = 2'd0;
    localparam logic [1:0] IN_SET   = 2'd1;
    localparam logic [1:0] IN_HOLD  = 2'd2;
    localparam logic [1:0] OUT_INIT = 2'd0;
    localparam logic [1:0] OUT_WAIT = 2'd1;
    localparam logic [1:0] OUT_IDLE = 2'd2;
    localparam logic [1:0] OUT_BUSY = 2'd3;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              tx_ready_q;
    logic [1:0]        in_st_q, in_st_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [DATA_W-1:0] inpr_q, inpr_d;
    logic              fgiset_q;
    logic [1:0]        out_st_q, out_st_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic              rx_valid_q, fgoset_q;
    logic              push, pop, fgi_done, capture, lat_done;
    assign push     = io_tx_valid & tx_ready_q;
    // The machine clearing FGI in HOLD means it has executed INP on the offered char.
    assign fgi_done = (in_st_q == IN_HOLD) & ~io_fgi;
    assign pop      = (in_st_q == IN_IDLE) & (cnt_q != '0) & ~io_fgi & (gap_q == '0);
    assign capture  = (out_st_q == OUT_IDLE) & ~io_fgo;
    assign lat_done = (out_st_q == OUT_BUSY) & (lat_q == LW'(1));
    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        in_st_d   = pop ? IN_SET :
                    ((in_st_q == IN_SET) & io_fgi) ? IN_HOLD :
                    fgi_done ? IN_IDLE : in_st_q;
        gap_d     = fgi_done ? GW'(IN_GAP) :
                    ((in_st_q == IN_IDLE) & (gap_q != '0)) ? gap_q - GW'(1) : gap_q;
        inpr_d    = pop ? mem_q[rd_ptr_q] : inpr_q;
        out_st_d  = (out_st_q == OUT_INIT) ? OUT_WAIT :
                    ((out_st_q == OUT_WAIT) & io_fgo) ? OUT_IDLE :
                    capture ? OUT_BUSY :
                    lat_done ? OUT_WAIT : out_st_q;
        lat_d     = capture ? LW'(OUT_LAT) :
                    ((out_st_q == OUT_BUSY) & ~lat_done) ? lat_q - LW'(1) : lat_q;
        rx_data_d = capture ? io_outr : rx_data_q;
        rx_cnt_d  = rx_cnt_q + CNT_W'(capture);
    end
    always_ff @(posedge io_clock)
        if (push) mem_q[wr_ptr_q] <= io_tx_data;
    always_ff @(posedge io_clock) begin
        if (io_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            tx_ready_q <= 1'b1;
            in_st_q    <= IN_IDLE;
            gap_q      <= '0;
            inpr_q     <= '0;
            fgiset_q   <= 1'b0;
            out_st_q   <= OUT_INIT;
            lat_q      <= '0;
            rx_data_q  <= '0;
            rx_cnt_q   <= '0;
            rx_valid_q <= 1'b0;
            fgoset_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            // Readiness follows the registered count, so a full FIFO refuses a push even alongside a pop.
            tx_ready_q <= cnt_d != (AW+1)'(FIFO_DEPTH);
            in_st_q    <= in_st_d;
            gap_q      <= gap_d;
            inpr_q     <= inpr_d;
            fgiset_q   <= pop;
            out_st_q   <= out_st_d;
            lat_q      <= lat_d;
            rx_data_q  <= rx_data_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_valid_q <= capture;
            fgoset_q   <= (out_st_q == OUT_INIT) | lat_done;
        end
    end
    assign io_tx_ready = tx_ready_q;
    assign io_fgiset   = fgiset_q;
    assign io_inpr     = inpr_q;
    assign io_fgoset   = fgoset_q;
    assign io_rx_valid = rx_valid_q;
    assign io_rx_data  = rx_data_q;
    assign io_rx_count = rx_cnt_q;
endmodule

// File: tb/tb_mano_io_channel.sv
// tb_mano_io_channel: scoreboard bench for mano_io_channel with host, machine-side responders and a monitor
module tb_mano_io_channel;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int GAP   = 4;
    localparam int LAT   = 8;
    localparam int CW    = 4;
    localparam int BIG   = 1 << 30;
    typedef struct { logic [DW-1:0] d; int t; } in_t;
    typedef struct { logic [DW-1:0] d; logic [CW-1:0] c; int t; } rx_t;
    logic clk = 1'b0;
    logic io_reset = 1'b1;
    logic tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic fgi_r = 1'b0, fgi_hold = 1'b0, fgi;
    logic fgo = 1'b0;
    logic [DW-1:0] outr = '0;
    logic tx_ready, fgiset, fgoset, rx_valid;
    logic [DW-1:0] inpr, rx_data;
    logic [CW-1:0] rx_count;
    assign fgi = fgi_r | fgi_hold;
    int cyc = 0, vecs = 0, errs = 0, in_ready = BIG, rx_n = 0;
    bit auto_in = 0, auto_out = 0, pend_in = 0, pend_out = 0, in_busy = 0, out_busy = 0;
    in_t in_q[$];
    rx_t out_q[$];
    int fgo_due[$];
    logic [DW-1:0] outr_q[$];

    mano_io_channel #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .IN_GAP(GAP), .OUT_LAT(LAT), .CNT_W(CW)) dut (
        .io_clock(clk), .io_reset(io_reset),
        .io_tx_valid(tx_valid), .io_tx_data(tx_data), .io_tx_ready(tx_ready),
        .io_fgi(fgi), .io_fgiset(fgiset), .io_inpr(inpr),
        .io_fgo(fgo), .io_outr(outr), .io_fgoset(fgoset),
        .io_rx_valid(rx_valid), .io_rx_data(rx_data), .io_rx_count(rx_count)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required to finish", cyc);
        $fatal(1);
    end

    function automatic int mx(input int a, input int b);
        return a > b ? a : b;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask
    task automatic bad(input string nm);
        vecs++;
        errs++;
        $display("FAIL %s @%0d", nm, cyc);
    endtask
    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask
    // Machine clears FGO now; capture happens on the next edge, FGO is re-set LAT cycles after that.
    task automatic expect_capture(input logic [DW-1:0] d);
        rx_n++;
        out_q.push_back('{d, CW'(rx_n), cyc + 1});
        fgo_due.push_back(cyc + 1 + LAT);
    endtask
    // Host offers a char this cycle; accepted iff the modelled FIFO holds fewer than DEPTH chars.
    task automatic push(input logic [DW-1:0] d);
        bit exp;
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        #1;
        exp = in_q.size() < DEPTH;
        chk("tx_ready", 32'(tx_ready), 32'(exp));
        if (exp) in_q.push_back('{d, cyc + 1});
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        io_reset = 1'b1;
        tx_valid = 1'b0;
        fgi_r = 1'b0;
        fgi_hold = 1'b0;
        fgo = 1'b0;
        tick(1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_fgiset", 32'(fgiset), 32'd0);
        chk("rst_fgoset", 32'(fgoset), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_inpr", 32'(inpr), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_count", 32'(rx_count), 32'd0);
        in_q.delete();
        out_q.delete();
        fgo_due.delete();
        pend_in = 0;
        pend_out = 0;
        rx_n = 0;
        tick(1);
        io_reset = 1'b0;
        fgo_due.push_back(cyc + 1);
        in_ready = cyc + 1;
    endtask
    task automatic settle_in(input int budget);
        int n = 0;
        while (in_q.size() > 0 || in_busy || pend_in) begin
            if (n == budget) begin
                bad("input side did not drain within budget");
                break;
            end
            tick(1);
            n++;
        end
    endtask
    task automatic settle_out(input int budget);
        int n = 0;
        while (out_q.size() > 0 || fgo_due.size() > 0 || out_busy) begin
            if (n == budget) begin
                bad("output side did not drain within budget");
                break;
            end
            tick(1);
            n++;
        end
    endtask

    // Machine input side: after each FGI set, raise FGI, then clear it (executes INP).
    initial forever begin
        @(posedge clk);
        #1;
        if (auto_in && pend_in) begin
            in_busy = 1;
            pend_in = 0;
            tick($urandom_range(0, 2));
            fgi_r = 1'b1;
            tick($urandom_range(1, 3));
            fgi_r = 1'b0;
            in_ready = cyc + GAP + 2;
            in_busy = 0;
        end
    end
    // Machine output side: after each FGO set, raise FGO, then clear it with a new OUTR char.
    initial forever begin
        @(posedge clk);
        #1;
        if (auto_out && pend_out) begin
            out_busy = 1;
            pend_out = 0;
            tick($urandom_range(0, 2));
            fgo = 1'b1;
            tick($urandom_range(1, 3));
            outr = outr_q.size() > 0 ? outr_q.pop_front() : DW'($urandom);
            fgo = 1'b0;
            expect_capture(outr);
            out_busy = 0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT pulses, and flags pulses that are late or missing.
    initial begin
        in_t e;
        rx_t r;
        bit pf = 0, po = 0, pr = 0;
        forever begin
            @(negedge clk);
            if (!io_reset) begin
                if (fgiset) begin
                    if (in_q.size() == 0) bad("fgiset pulse with no char queued");
                    else begin
                        e = in_q.pop_front();
                        chk("inpr", 32'(inpr), 32'(e.d));
                        chk("fgiset_cycle", cyc, mx(in_ready, e.t + 1));
                    end
                    in_ready = BIG;
                    pend_in = 1;
                end else if (in_q.size() > 0 && cyc == mx(in_ready, in_q[0].t + 1))
                    bad("fgiset missing: got 0, expected pulse");
                if (rx_valid) begin
                    if (out_q.size() == 0) bad("rx_valid pulse with no capture expected");
                    else begin
                        r = out_q.pop_front();
                        chk("rx_data", 32'(rx_data), 32'(r.d));
                        chk("rx_count", 32'(rx_count), 32'(r.c));
                        chk("rx_cycle", cyc, r.t);
                    end
                end else if (out_q.size() > 0 && cyc == out_q[0].t)
                    bad("rx_valid missing: got 0, expected pulse");
                if (fgoset) begin
                    if (fgo_due.size() == 0) bad("fgoset pulse with none expected");
                    else chk("fgoset_cycle", cyc, fgo_due.pop_front());
                    pend_out = 1;
                end else if (fgo_due.size() > 0 && cyc == fgo_due[0]) begin
                    bad("fgoset missing: got 0, expected pulse");
                    void'(fgo_due.pop_front());
                end
                if (fgiset && pf) bad("fgiset high two cycles in a row");
                if (fgoset && po) bad("fgoset high two cycles in a row");
                if (rx_valid && pr) bad("rx_valid high two cycles in a row");
            end
            pf = fgiset;
            po = fgoset;
            pr = rx_valid;
        end
    end

    initial begin
        int n;
        @(posedge clk);
        #1;
        do_reset();
        tick(20);
        outr_q.push_back(8'h5A);
        auto_out = 1;
        auto_in = 1;
        push(8'h41);
        push(8'h42);
        tx_valid = 1'b0;
        settle_in(400);
        tick(GAP + 3);
        fgi_hold = 1'b1;
        in_ready = BIG;
        for (int i = 0; i < DEPTH + 1; i++) push(DW'(i));
        tx_valid = 1'b0;
        tick(1);
        chk("tx_ready_full", 32'(tx_ready), 32'(in_q.size() < DEPTH));
        fgi_hold = 1'b0;
        in_ready = cyc + 1;
        settle_in(2000);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) push(DW'($urandom));
            else begin
                tx_valid = 1'b0;
                tick(1);
            end
        end
        tx_valid = 1'b0;
        n = 0;
        while (rx_n < 20) begin
            if (n == 2000) begin
                bad("too few captures for count wrap");
                break;
            end
            tick(1);
            n++;
        end
        settle_in(3000);
        auto_out = 0;
        settle_out(200);
        auto_in = 0;
        push(8'h77);
        tx_valid = 1'b0;
        n = 0;
        while (in_q.size() > 0) begin
            if (n == 50) begin
                bad("fgiset for 8'h77 never came");
                break;
            end
            tick(1);
            n++;
        end
        push(8'h78);
        tx_valid = 1'b0;
        fgo = 1'b1;
        tick(2);
        outr = 8'hC3;
        fgo = 1'b0;
        expect_capture(outr);
        tick(3);
        do_reset();
        tick(15);
        chk("tx_ready_after_reset", 32'(tx_ready), 32'(in_q.size() < DEPTH));
        auto_in = 1;
        auto_out = 1;
        push(8'h99);
        tx_valid = 1'b0;
        settle_in(200);
        auto_out = 0;
        settle_out(200);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
